// File: rtl/mem_ctrl.sv
// Data-memory / MMIO controller between the CPU load/store unit and on-chip RAM.
// Decodes a RAM window and a two-register MMIO window (GPIO at +0, timer at +4),
// performs byte/half/word loads with optional sign extension, and byte-lane
// stores through read-modify-write. Misaligned or unmapped accesses are flagged
// on memFault without side effects.
// Optional feature: define MEM_CTRL_TIMER_EN to build the free-running cycle
// counter readable at MMIO_BASE+4; otherwise that register reads as zero.

module ram #(
  parameter int unsigned RAM_SIZE = 32768,
  localparam int unsigned AW = (RAM_SIZE >= 8) ? $clog2(RAM_SIZE / 4) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(2**AW)-1];

  // Word-wide synchronous RAM, one-cycle read latency, read-before-write
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

module mem_ctrl #(
  parameter int unsigned RAM_SIZE  = 32768,
  parameter logic [31:0] RAM_BASE  = 32'h0,
  parameter logic [31:0] MMIO_BASE = 32'h10000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        memReady,
  output logic        dataReady,
  output logic        memFault,
  input  logic        memExecute,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  input  logic [31:0] memAddress,
  input  logic [31:0] inputData,
  output logic [31:0] outputData,
  output logic        ledState,
  output logic [7:0]  sevenSeg,
  output logic [3:0]  sevenSegEn
);

  localparam int unsigned AW = (RAM_SIZE >= 8) ? $clog2(RAM_SIZE / 4) : 1;

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_WAIT,
    S_MERGE,
    S_RESP,
    S_FAULT
  } state_t;

  state_t      state;

  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic        write_q;
  logic        mmio_hi_q;
  logic [31:0] rd_reg;
  logic [12:0] gpio;
  logic [31:0] timer;

  logic [31:0] ram_off_in;
  logic [31:0] mmio_off_in;
  logic        ram_hit;
  logic        mmio_hit;
  logic        misalign;
  logic        fault_in;

  logic [31:0] sel_off;
  logic [AW-1:0] ram_idx;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Request decode on the live inputs; only meaningful in the accept cycle
  always_comb begin
    ram_off_in  = memAddress - RAM_BASE;
    mmio_off_in = memAddress - MMIO_BASE;
    ram_hit     = ram_off_in < 32'(RAM_SIZE);
    mmio_hit    = mmio_off_in < 32'd8;
    misalign    = (memSize == 2'b11)
                | ((memSize == 2'b01) & memAddress[0])
                | ((memSize == 2'b10) & (memAddress[1:0] != 2'b00));
    // Priority collapses to a plain OR: each later rule only adds faults the
    // earlier ones did not already raise, and every fault leads to S_FAULT.
    fault_in    = misalign
                | ~(ram_hit | mmio_hit)
                | (~ram_hit & (memSize != 2'b10));
  end

  // RAM port: live address during accept, latched address afterwards
  always_comb begin
    sel_off = ((state == S_IDLE) ? memAddress : addr_q) - RAM_BASE;
    ram_idx = AW'(sel_off >> 2);
    ram_we  = (state == S_MERGE) & reset_n;
    ram_en  = ram_we
            | ((state == S_IDLE) & memExecute & ram_hit & ~fault_in & reset_n);
  end

  // Store merge of the selected byte lane(s) into the fetched word
  always_comb begin
    merged = rd_reg;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = data_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: merged = data_q;
    endcase
  end

  // Load alignment and sign/zero extension of the fetched word
  always_comb begin
    shifted = rd_reg >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  ram #(.RAM_SIZE(RAM_SIZE)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (merged),
    .rdata (ram_rdata)
  );

`ifdef MEM_CTRL_TIMER_EN
  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!reset_n) timer <= '0;
    else          timer <= timer + 32'd1;
  end
`else
  assign timer = '0;
`endif

  // Controller FSM with registered outputs and GPIO register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_RST;
      memReady   <= 1'b0;
      dataReady  <= 1'b0;
      memFault   <= 1'b0;
      outputData <= '0;
      gpio       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      write_q    <= 1'b0;
      mmio_hi_q  <= 1'b0;
      rd_reg     <= '0;
    end else begin
      case (state)
        S_RST: begin
          state    <= S_IDLE;
          memReady <= 1'b1;
        end
        S_IDLE: begin
          if (memExecute) begin
            addr_q    <= memAddress;
            data_q    <= inputData;
            size_q    <= memSize;
            sign_q    <= memSign;
            write_q   <= memWrite;
            mmio_hi_q <= mmio_off_in[2];
            dataReady <= 1'b0;
            memFault  <= 1'b0;
            memReady  <= 1'b0;
            if (fault_in)     state <= S_FAULT;
            else if (ram_hit) state <= S_WAIT;
            else              state <= S_RESP;
          end
        end
        S_WAIT: begin
          rd_reg <= ram_rdata;
          state  <= write_q ? S_MERGE : S_RESP;
        end
        S_MERGE: begin
          state    <= S_IDLE;
          memReady <= 1'b1;
        end
        S_RESP: begin
          if (addr_q - RAM_BASE < 32'(RAM_SIZE)) begin
            outputData <= load_val;
            dataReady  <= 1'b1;
          end else if (write_q) begin
            if (!mmio_hi_q) gpio <= data_q[12:0];
          end else begin
            outputData <= mmio_hi_q ? timer : {19'b0, gpio};
            dataReady  <= 1'b1;
          end
          state    <= S_IDLE;
          memReady <= 1'b1;
        end
        S_FAULT: begin
          memFault <= 1'b1;
          if (!write_q) begin
            dataReady  <= 1'b1;
            outputData <= '0;
          end
          state    <= S_IDLE;
          memReady <= 1'b1;
        end
        default: begin
          state    <= S_RST;
          memReady <= 1'b0;
        end
      endcase
    end
  end

  assign ledState   = gpio[0];
  assign sevenSeg   = gpio[8:1];
  assign sevenSegEn = gpio[12:9];

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed table, randomized traffic against a
// byte-level memory/GPIO/timer reference model, timer spacing and mid-store reset.
// Honours MEM_CTRL_TIMER_EN the same way as the design.

module tb_mem_ctrl;

  localparam logic [31:0] RB = 32'h0;
  localparam logic [31:0] RS = 32'd32768;
  localparam logic [31:0] MB = 32'h10000;

  logic        clk;
  logic        reset_n;
  logic        memReady;
  logic        dataReady;
  logic        memFault;
  logic        memExecute;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSign;
  logic [31:0] memAddress;
  logic [31:0] inputData;
  logic [31:0] outputData;
  logic        ledState;
  logic [7:0]  sevenSeg;
  logic [3:0]  sevenSegEn;

  int vec_count  = 0;
  int miscompares = 0;

  logic [7:0]  mem_model [int unsigned];
  logic [12:0] gpio_model;
  logic [31:0] tcount;

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] q;
    bit          chk_q;
    bit          f;
    bit          dr;
    int          lat;
    logic [12:0] gp;
  } vec_t;

  vec_t dir_tbl [$];

  mem_ctrl #(.RAM_SIZE(32768), .RAM_BASE(32'h0), .MMIO_BASE(32'h10000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .memReady   (memReady),
    .dataReady  (dataReady),
    .memFault   (memFault),
    .memExecute (memExecute),
    .memWrite   (memWrite),
    .memSize    (memSize),
    .memSign    (memSign),
    .memAddress (memAddress),
    .inputData  (inputData),
    .outputData (outputData),
    .ledState   (ledState),
    .sevenSeg   (sevenSeg),
    .sevenSegEn (sevenSegEn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle count since the last reset edge
  always @(posedge clk) tcount <= (reset_n === 1'b1) ? tcount + 32'd1 : 32'd0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Timer value captured by a load whose response edge was the latest posedge
  function automatic logic [31:0] timer_now();
`ifdef MEM_CTRL_TIMER_EN
    return tcount - 32'd1;
`else
    return 32'd0;
`endif
  endfunction

  // Reference model: applies one access to the byte memory / GPIO and reports the
  // expected fault flag, latency, dataReady and load value.
  task automatic model_access(input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] d,
                              output bit f, output int lat, output bit dr,
                              output logic [31:0] q, output bit tmr);
    int unsigned n;
    bit in_ram, in_mmio, mis;
    logic [31:0] v;
    n       = 1 << sz;
    mis     = (sz == 2'd3) || ((a % n) != 0);
    in_ram  = (a >= RB) && ((a - RB) < RS);
    in_mmio = (a >= MB) && ((a - MB) < 32'd8);
    f       = mis || !(in_ram || in_mmio) || (!in_ram && sz != 2'd2);
    q       = '0;
    tmr     = 1'b0;
    dr      = !wr;
    lat     = f ? 1 : (in_ram ? 2 : 1);
    if (f) return;
    if (in_ram) begin
      if (wr) begin
        for (int unsigned i = 0; i < n; i++) mem_model[a + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(mem_model[a + i]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        q = v;
      end
    end else if (wr) begin
      if (a == MB) gpio_model = d[12:0];
    end else if (a == MB) begin
      q = {19'b0, gpio_model};
    end else begin
      tmr = 1'b1;
    end
  endtask

  // Issue one request, scramble inputs after accept, wait (bounded) for memReady
  task automatic do_access(input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] d, input bit hold,
                           output logic [31:0] q, output logic f, output logic dr,
                           output int lat);
    @(negedge clk);
    memExecute = 1'b1;
    memWrite   = wr;
    memSize    = sz;
    memSign    = sg;
    memAddress = a;
    inputData  = d;
    @(posedge clk);
    #1;
    memExecute = hold;
    memWrite   = 1'($urandom);
    memSize    = 2'($urandom);
    memSign    = 1'($urandom);
    memAddress = $urandom_range(0, 32'h3FF);
    inputData  = $urandom;
    lat = 0;
    while (memReady !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    memExecute = 1'b0;
    q  = outputData;
    f  = memFault;
    dr = dataReady;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    memExecute = 1'b0;
    memWrite   = 1'b0;
    memSize    = 2'b00;
    memSign    = 1'b0;
    memAddress = '0;
    inputData  = '0;
    gpio_model = '0;
    repeat (3) @(posedge clk);
    #1;
    vec_count++;
    if ({memReady, dataReady, memFault, outputData, ledState, sevenSeg, sevenSegEn} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0",
               {memReady, dataReady, memFault, outputData, ledState, sevenSeg, sevenSegEn});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    vec_count++;
    if (memReady !== 1'b1 || dataReady !== 1'b0 || memFault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready/dr/fault got %b%b%b want 100", memReady, dataReady, memFault);
    end
  endtask

  task automatic test_preload();
    logic [31:0] q, eq, d;
    logic f, dr;
    bit ef, edr, tmr;
    int lat, elat;
    for (int unsigned a = 0; a < 32'h400; a += 4) begin
      d = $urandom;
      model_access(1'b1, 2'd2, 1'b0, a, d, ef, elat, edr, eq, tmr);
      do_access(1'b1, 2'd2, 1'b0, a, d, 1'b0, q, f, dr, lat);
      vec_count++;
      if (lat !== elat || f !== ef || dr !== edr) begin
        miscompares++;
        $display("FAIL preload @%h lat/fault/dr got %0d/%b/%b want %0d/%b/%b",
                 a, lat, f, dr, elat, ef, edr);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] q, eq;
    logic f, dr;
    bit ef, edr, tmr;
    int lat, elat;
    vec_t v;
    dir_tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h100,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h101,   32'h55,       32'h0,        1'b0, 1'b0, 1'b0, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        32'hDEAD55EF, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h103,   32'h0,        32'hFFFFFFDE, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h103,   32'h0,        32'h000000DE, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h102,   32'h0,        32'hFFFFDEAD, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h101,   32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        32'hDEAD55EF, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h102,   32'h1234,     32'h0,        1'b0, 1'b0, 1'b0, 2, 13'h0});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        32'h123455EF, 1'b1, 1'b0, 1'b1, 2, 13'h0});
    dir_tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10000, 32'h0000FFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1, 13'h1FFF});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10000, 32'h0,        32'h00001FFF, 1'b1, 1'b0, 1'b1, 1, 13'h1FFF});
    dir_tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h10000, 32'hAA,       32'h0,        1'b0, 1'b1, 1'b0, 1, 13'h1FFF});
    dir_tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h8000,  32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1, 13'h1FFF});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10008, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1, 13'h1FFF});
    dir_tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h100,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1, 13'h1FFF});
    dir_tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        32'h123455EF, 1'b1, 1'b0, 1'b1, 2, 13'h1FFF});
    foreach (dir_tbl[i]) begin
      v = dir_tbl[i];
      model_access(v.wr, v.sz, v.sg, v.a, v.d, ef, elat, edr, eq, tmr);
      do_access(v.wr, v.sz, v.sg, v.a, v.d, 1'b0, q, f, dr, lat);
      vec_count++;
      if (lat !== v.lat) begin
        miscompares++;
        $display("FAIL dir%0d latency got %0d want %0d", i, lat, v.lat);
      end
      vec_count++;
      if (f !== v.f || dr !== v.dr) begin
        miscompares++;
        $display("FAIL dir%0d fault/dataReady got %b/%b want %b/%b", i, f, dr, v.f, v.dr);
      end
      if (v.chk_q) begin
        vec_count++;
        if (q !== v.q) begin
          miscompares++;
          $display("FAIL dir%0d outputData got %h want %h", i, q, v.q);
        end
      end
      vec_count++;
      if ({sevenSegEn, sevenSeg, ledState} !== v.gp) begin
        miscompares++;
        $display("FAIL dir%0d gpio got %h want %h", i, {sevenSegEn, sevenSeg, ledState}, v.gp);
      end
    end
  endtask

  task automatic test_random(input int count);
    logic [31:0] q, eq, a, d;
    logic [1:0] sz;
    logic f, dr;
    bit ef, edr, tmr, wr, sg, hold;
    int lat, elat, cls;
    for (int k = 0; k < count; k++) begin
      cls = $urandom_range(0, 9);
      if (cls <= 5)      a = $urandom_range(0, 32'h3FF);
      else if (cls <= 7) a = MB + $urandom_range(0, 7);
      else if (cls == 8) a = 32'h8000 + $urandom_range(0, 32'h7FFF);
      else               a = MB + 32'd8 + $urandom_range(0, 32'hFFF);
      sz   = 2'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      wr   = 1'($urandom);
      sg   = 1'($urandom);
      hold = 1'($urandom);
      d    = $urandom;
      model_access(wr, sz, sg, a, d, ef, elat, edr, eq, tmr);
      do_access(wr, sz, sg, a, d, hold, q, f, dr, lat);
      if (tmr) eq = timer_now();
      vec_count++;
      if (lat !== elat || f !== ef || dr !== edr) begin
        miscompares++;
        $display("FAIL rnd%0d @%h wr%b sz%0d lat/fault/dr got %0d/%b/%b want %0d/%b/%b",
                 k, a, wr, sz, lat, f, dr, elat, ef, edr);
      end
      if (!wr) begin
        vec_count++;
        if (q !== eq) begin
          miscompares++;
          $display("FAIL rnd%0d load @%h sz%0d sg%b got %h want %h", k, a, sz, sg, q, eq);
        end
      end
      vec_count++;
      if ({sevenSegEn, sevenSeg, ledState} !== gpio_model) begin
        miscompares++;
        $display("FAIL rnd%0d gpio got %h want %h", k, {sevenSegEn, sevenSeg, ledState}, gpio_model);
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] q1, q2, want;
    logic f, dr;
    int lat;
    do_access(1'b0, 2'd2, 1'b0, MB + 32'd4, 32'h0, 1'b0, q1, f, dr, lat);
    want = timer_now();
    vec_count++;
    if (q1 !== want || f !== 1'b0 || dr !== 1'b1) begin
      miscompares++;
      $display("FAIL timer_first got %h/%b/%b want %h/0/1", q1, f, dr, want);
    end
    repeat (8) @(posedge clk);
    do_access(1'b0, 2'd2, 1'b0, MB + 32'd4, 32'h0, 1'b0, q2, f, dr, lat);
`ifdef MEM_CTRL_TIMER_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    vec_count++;
    if (q2 - q1 !== want) begin
      miscompares++;
      $display("FAIL timer_delta got %0d want %0d", q2 - q1, want);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, eq;
    logic f, dr;
    bit ef, edr, tmr;
    int lat, elat;
    model_access(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, ef, elat, edr, eq, tmr);
    do_access(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 1'b0, q, f, dr, lat);
    @(negedge clk);
    memExecute = 1'b1;
    memWrite   = 1'b1;
    memSize    = 2'd2;
    memSign    = 1'b0;
    memAddress = 32'h200;
    inputData  = 32'h12345678;
    @(posedge clk);
    #1;
    memExecute = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    gpio_model = '0;
    vec_count++;
    if ({memReady, dataReady, memFault, outputData, ledState, sevenSeg, sevenSegEn} !== 48'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h want 0",
               {memReady, dataReady, memFault, outputData, ledState, sevenSeg, sevenSegEn});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    vec_count++;
    if (memReady !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_ready got %b want 1", memReady);
    end
    model_access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, ef, elat, edr, eq, tmr);
    do_access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b0, q, f, dr, lat);
    vec_count++;
    if (q !== 32'hCAFEF00D || eq !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL midreset_word got %h want %h", q, 32'hCAFEF00D);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_directed();
    test_random(500);
    test_timer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
